// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and FSM state type for the register-file write arbiter
package regfile_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - two-request round-robin pick with per-request eligibility and LAST pointer
module rr_arbiter (
  input  logic req0,
  input  logic req1,
  input  logic elig0,
  input  logic elig1,
  input  logic last_in,
  output logic win0,
  output logic win1,
  output logic any_win,
  output logic last_out
);

  logic e0;
  logic e1;

  assign e0 = req0 & elig0;
  assign e1 = req1 & elig1;

  // last_in=1 means requester 1 was granted last, so requester 0 takes a tie
  assign win0     = e0 & (~e1 | last_in);
  assign win1     = e1 & (~e0 | ~last_in);
  assign any_win  = e0 | e1;
  assign last_out = win1 ? 1'b1 : (win0 ? 1'b0 : last_in);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-port register-file write arbiter; optional pending-write scoreboard under HAZARD_DETECT_EN
module regfile_wr_arbiter
  import regfile_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic [REG_ADDR_W-1:0] DR0,
  input  logic [REG_ADDR_W-1:0] DR1,
  input  logic [DATA_W-1:0]     D0,
  input  logic [DATA_W-1:0]     D1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  LD,
  output logic [REG_ADDR_W-1:0] DR,
  output logic [DATA_W-1:0]     D_in,
  input  logic                  RSV,
  input  logic [REG_ADDR_W-1:0] RSV_DR,
  input  logic [REG_ADDR_W-1:0] SA,
  input  logic [REG_ADDR_W-1:0] SB,
  output logic                  HAZ_A,
  output logic                  HAZ_B
);

  wr_state_t             state;
  wr_state_t             state_n;
  logic                  last;
  logic                  last_n;
  logic                  gnt0_n;
  logic                  gnt1_n;
  logic [REG_ADDR_W-1:0] dr_n;
  logic [DATA_W-1:0]     d_n;
  logic                  win0;
  logic                  win1;
  logic                  any_win;
  logic                  arb_last;

  // a requester whose grant is showing this cycle is still holding the old request
  rr_arbiter u_arb (
    .req0     (REQ0),
    .req1     (REQ1),
    .elig0    (~GNT0),
    .elig1    (~GNT1),
    .last_in  (last),
    .win0     (win0),
    .win1     (win1),
    .any_win  (any_win),
    .last_out (arb_last)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      last  <= 1'b1;
      GNT0  <= 1'b0;
      GNT1  <= 1'b0;
      DR    <= '0;
      D_in  <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      GNT0  <= gnt0_n;
      GNT1  <= gnt1_n;
      DR    <= dr_n;
      D_in  <= d_n;
    end
  end

  always_comb begin
    state_n = IDLE;
    last_n  = last;
    gnt0_n  = 1'b0;
    gnt1_n  = 1'b0;
    dr_n    = DR;
    d_n     = D_in;
    case (state)
      IDLE, WRITE: begin
        if (any_win) begin
          state_n = WRITE;
          last_n  = arb_last;
          gnt0_n  = win0;
          gnt1_n  = win1;
          dr_n    = win0 ? DR0 : DR1;
          d_n     = win0 ? D0 : D1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign LD = (state == WRITE);

`ifdef HAZARD_DETECT_EN
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_n;

  // reservation is applied after the write clear so a same-register set wins
  always_comb begin
    pending_n = pending;
    if (LD)
      pending_n[DR] = 1'b0;
    if (RSV)
      pending_n[RSV_DR] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      pending <= '0;
    else
      pending <= pending_n;
  end

  assign HAZ_A = pending[SA];
  assign HAZ_B = pending[SB];
`else
  logic unused_hazard_inputs;
  assign unused_hazard_inputs = ^{RSV, RSV_DR, SA, SB};
  assign HAZ_A = 1'b0;
  assign HAZ_B = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed self-checking bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

  logic       CLK;
  logic       RST;
  logic       REQ0;
  logic       REQ1;
  logic [2:0] DR0;
  logic [2:0] DR1;
  logic [7:0] D0;
  logic [7:0] D1;
  logic       GNT0;
  logic       GNT1;
  logic       LD;
  logic [2:0] DR;
  logic [7:0] D_in;
  logic       RSV;
  logic [2:0] RSV_DR;
  logic [2:0] SA;
  logic [2:0] SB;
  logic       HAZ_A;
  logic       HAZ_B;

  int checks;
  int errors;

  regfile_wr_arbiter dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ0   (REQ0),
    .REQ1   (REQ1),
    .DR0    (DR0),
    .DR1    (DR1),
    .D0     (D0),
    .D1     (D1),
    .GNT0   (GNT0),
    .GNT1   (GNT1),
    .LD     (LD),
    .DR     (DR),
    .D_in   (D_in),
    .RSV    (RSV),
    .RSV_DR (RSV_DR),
    .SA     (SA),
    .SB     (SB),
    .HAZ_A  (HAZ_A),
    .HAZ_B  (HAZ_B)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic g0, input logic g1, input logic ld,
                         input logic [2:0] dr, input logic [7:0] d);
    chk({tag, ".gnt0"}, {7'd0, GNT0}, {7'd0, g0});
    chk({tag, ".gnt1"}, {7'd0, GNT1}, {7'd0, g1});
    chk({tag, ".ld"},   {7'd0, LD},   {7'd0, ld});
    chk({tag, ".dr"},   {5'd0, DR},   {5'd0, dr});
    chk({tag, ".d_in"}, D_in, d);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    DR0 = 3'd0; DR1 = 3'd0; D0 = 8'h00; D1 = 8'h00;
    RSV = 1'b0; RSV_DR = 3'd0; SA = 3'd0; SB = 3'd0;

    // reset state
    repeat (2) @(negedge CLK);
    chk_out("reset", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    chk("reset.haz_a", {7'd0, HAZ_A}, 8'h00);
    chk("reset.haz_b", {7'd0, HAZ_B}, 8'h00);

    // single request: one-cycle latency, then idle holds DR/D_in
    RST = 1'b0;
    REQ0 = 1'b1; DR0 = 3'd3; D0 = 8'hA5;
    @(negedge CLK);
    chk_out("single", 1'b1, 1'b0, 1'b1, 3'd3, 8'hA5);
    REQ0 = 1'b0;
    @(negedge CLK);
    chk_out("single_drop", 1'b0, 1'b0, 1'b0, 3'd3, 8'hA5);

    // both held from reset: 0,1,0,1
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    REQ0 = 1'b1; DR0 = 3'd1; D0 = 8'h11;
    REQ1 = 1'b1; DR1 = 3'd2; D1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (i % 2 == 0) chk_out("alt", 1'b1, 1'b0, 1'b1, 3'd1, 8'h11);
      else            chk_out("alt", 1'b0, 1'b1, 1'b1, 3'd2, 8'h22);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);
    chk_out("idle_hold", 1'b0, 1'b0, 1'b0, 3'd2, 8'h22);

    // same destination from both: later grant's data is final
    REQ0 = 1'b1; DR0 = 3'd6; D0 = 8'h66;
    REQ1 = 1'b1; DR1 = 3'd6; D1 = 8'h77;
    @(negedge CLK);
    chk_out("same_dr0", 1'b1, 1'b0, 1'b1, 3'd6, 8'h66);
    @(negedge CLK);
    chk_out("same_dr1", 1'b0, 1'b1, 1'b1, 3'd6, 8'h77);
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);
    chk_out("same_dr_final", 1'b0, 1'b0, 1'b0, 3'd6, 8'h77);

    // requester 0 held alone: no back-to-back grant
    REQ0 = 1'b1; DR0 = 3'd7; D0 = 8'h5A;
    @(negedge CLK);
    chk_out("hold0_c1", 1'b1, 1'b0, 1'b1, 3'd7, 8'h5A);
    @(negedge CLK);
    chk_out("hold0_c2", 1'b0, 1'b0, 1'b0, 3'd7, 8'h5A);
    @(negedge CLK);
    chk_out("hold0_c3", 1'b1, 1'b0, 1'b1, 3'd7, 8'h5A);
    @(negedge CLK);
    chk_out("hold0_c4", 1'b0, 1'b0, 1'b0, 3'd7, 8'h5A);

    // LAST now points at 0, so the tie goes to requester 1
    REQ0 = 1'b1; DR0 = 3'd1; D0 = 8'h01;
    REQ1 = 1'b1; DR1 = 3'd2; D1 = 8'h02;
    @(negedge CLK);
    chk_out("tie_last0", 1'b0, 1'b1, 1'b1, 3'd2, 8'h02);
    @(negedge CLK);
    chk_out("pre_rst", 1'b1, 1'b0, 1'b1, 3'd1, 8'h01);

    // asynchronous reset mid-write with requester 1 pending
    #2 RST = 1'b1;
    #1 chk_out("async_rst", 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk_out("post_rst_tie", 1'b1, 1'b0, 1'b1, 3'd1, 8'h01);
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);

`ifdef HAZARD_DETECT_EN
    RSV = 1'b1; RSV_DR = 3'd5;
    @(negedge CLK);
    RSV = 1'b0; SA = 3'd5; SB = 3'd4;
    #1 chk("haz_a_set", {7'd0, HAZ_A}, 8'h01);
    chk("haz_b_clear", {7'd0, HAZ_B}, 8'h00);
    REQ0 = 1'b1; DR0 = 3'd5; D0 = 8'hC3;
    @(negedge CLK);
    chk("haz_a_during_ld", {7'd0, HAZ_A}, 8'h01);
    chk("ld_dr5", {5'd0, DR}, 8'h05);
    REQ0 = 1'b0;
    @(negedge CLK);
    chk("haz_a_after_ld", {7'd0, HAZ_A}, 8'h00);

    RSV = 1'b1; RSV_DR = 3'd4;
    REQ0 = 1'b1; DR0 = 3'd4; D0 = 8'h44;
    @(negedge CLK);
    chk("ld_dr4", {4'd0, LD, DR}, 8'h0C);
    REQ0 = 1'b0;
    @(negedge CLK);
    RSV = 1'b0;
    #1 chk("set_wins", {7'd0, HAZ_B}, 8'h01);
    @(negedge CLK);
    chk("set_wins_hold", {7'd0, HAZ_B}, 8'h01);
`else
    RSV = 1'b1; RSV_DR = 3'd5; SA = 3'd5; SB = 3'd5;
    @(negedge CLK);
    RSV = 1'b0;
    @(negedge CLK);
    chk("no_haz_a", {7'd0, HAZ_A}, 8'h00);
    chk("no_haz_b", {7'd0, HAZ_B}, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports exactly as follows.
REQ-002 CLK  input  1  clock, all state on rising edge.
REQ-003 RST  input  1  asynchronous active-high reset.
REQ-004 REQ0  input  1  requester 0 (ALU) write request; REQ1 input 1 requester 1 (memory load) write request.
REQ-005 DR0, DR1  input  3 each  destination register of requester 0 / 1.
REQ-006 D0, D1  input  8 each  write data of requester 0 / 1.
REQ-007 GNT0, GNT1  output  1 each  registered one-cycle acceptance pulse.
REQ-008 LD  output  1  register-file load enable.
REQ-009 DR  output  3  register-file destination select.
REQ-010 D_in  output  8  register-file write data.
REQ-011 RSV  input  1  reserve pending-write for RSV_DR; RSV_DR input 3.
REQ-012 SA, SB  input  3 each  read selects to check; HAZ_A, HAZ_B output 1 each  pending-write flag for SA / SB.

Function
REQ-013 Handshake: requester holds REQn, DRn, Dn stable until it sees GNTn=1, then drops REQn or presents a new request.
REQ-014 A requester whose GNTn is currently 1 SHALL be ineligible that cycle, so a held REQ is never double-granted.
REQ-015 Arbitration: among eligible REQs, single request wins; both eligible -> requester not granted last (pointer LAST) wins.
REQ-016 On the edge after a win: GNTn=1, LD=1, DR/D_in = winner's DRn/Dn, LAST=n; latency request-to-LD = 1 cycle.
REQ-017 No eligible request -> LD=0, GNT0=GNT1=0; DR and D_in hold previous values.
REQ-018 At most one GNT high per cycle; LD equals GNT0|GNT1.
REQ-019 Both requesters hold REQ continuously -> grants alternate 0,1,0,1 with LD=1 every cycle.
REQ-020 Same DR from both requesters -> written in grant order; later grant's data is final register content.
REQ-021 FSM states IDLE (LD=0) and WRITE (LD=1); IDLE->WRITE on eligible request, WRITE->WRITE on eligible request, else ->IDLE.

Reset
REQ-022 RST asserted: LD=0, GNT0=GNT1=0, DR=0, D_in=0, LAST=1 (requester 0 wins first tie), state IDLE, pending bits 0.
REQ-023 Reset mid-operation discards any un-granted request; requester SHALL re-request after RST deasserts.
REQ-024 First arbitration occurs on the first rising CLK edge with RST low.

Configuration
REQ-025 Macro HAZARD_DETECT_EN defined: 8-bit pending scoreboard; RSV sets pending[RSV_DR]; a write (LD=1) clears pending[DR]; simultaneous set and clear of same register -> set wins.
REQ-026 With HAZARD_DETECT_EN: HAZ_A=pending[SA], HAZ_B=pending[SB], combinational from registered bits.
REQ-027 Without HAZARD_DETECT_EN: no scoreboard flops, RSV/RSV_DR/SA/SB ignored, HAZ_A=HAZ_B=0; ports still present.

Structure
REQ-028 Shared package regfile_pkg SHALL hold DATA_W=8, REG_ADDR_W=3, NUM_REGS=8 and the FSM state typedef.
REQ-029 Arbitration logic SHALL be a sub-module rr_arbiter (2 requests, eligibility masks, LAST pointer in/out).

Verification
REQ-030 RST then REQ0=1, DR0=3, D0=8'hA5 -> next cycle GNT0=1, LD=1, DR=3, D_in=8'hA5; following cycle LD=0 if REQ0 dropped.
REQ-031 Both REQs held, DR0=1/D0=8'h11, DR1=2/D1=8'h22 from reset -> grant sequence 0,1,0,1, LD=1 each cycle.
REQ-032 REQ0 held 4 cycles alone -> GNT0 pattern 1,0,1,0 (no back-to-back grant of same requester).
REQ-033 HAZARD_DETECT_EN: RSV=1, RSV_DR=5, then SA=5 -> HAZ_A=1; grant write DR=5 -> HAZ_A=0 the cycle after LD.
REQ-034 RST pulsed while REQ1 pending and LD=1 -> LD, GNT0, GNT1 = 0 immediately; pending cleared; next tie grants requester 0.
REQ-035 RSV_DR=4 set in same cycle as LD write to DR=4 -> pending[4] remains 1.
